// File: rtl/breath_envelope_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | breath_envelope_if : control/status bundle of breath_envelope   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface breath_envelope_if #(
  parameter int DUTY_W = 10
);
  logic              enable;
  logic              key_n;
  logic [DUTY_W-1:0] duty;
  logic              period_start;
  logic [2:0]        state;
  logic [1:0]        speed;
  logic              key_evt;

  modport master (
    output enable, key_n,
    input  duty, period_start, state, speed, key_evt
  );

  modport slave (
    input  enable, key_n,
    output duty, period_start, state, speed, key_evt
  );
endinterface
`default_nettype wire

// File: rtl/breath_envelope.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | breath_envelope : PWM period strobe + ramp/hold duty envelope,  |
// |                   debounced key cycles the ramp speed           |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module breath_envelope #(
  parameter int CLK_PER_US   = 50,
  parameter int PERIOD_US    = 1000,
  parameter int DUTY_W       = 10,
  parameter int HOLD_PERIODS = 200,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  breath_envelope_if.slave bus
);

  localparam int c_pre_w  = (CLK_PER_US   > 1) ? $clog2(CLK_PER_US)   : 1;
  localparam int c_us_w   = (PERIOD_US    > 1) ? $clog2(PERIOD_US)    : 1;
  localparam int c_hold_w = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam int c_db_w   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int c_ext_w  = DUTY_W + 1;

  localparam logic [c_pre_w-1:0]  c_pre_last = c_pre_w'(CLK_PER_US - 1);
  localparam logic [c_us_w-1:0]   c_us_last  = c_us_w'(PERIOD_US - 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_PERIODS - 1);
  localparam logic [c_db_w-1:0]   c_db_last  = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [DUTY_W-1:0]   c_level_max = DUTY_W'(PERIOD_US - 1);
  localparam logic [c_ext_w-1:0]  c_level_ext = c_ext_w'(PERIOD_US - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  logic [c_pre_w-1:0]  r_pre;
  logic [c_us_w-1:0]   r_us;
  logic                r_period_start;
  logic                w_tick;
  logic                w_boundary;

  state_t              r_state, w_state_nxt;
  logic [DUTY_W-1:0]   r_duty, w_duty_nxt;
  logic [c_hold_w-1:0] r_hold, w_hold_nxt;
  logic [c_ext_w-1:0]  w_step;
  logic [c_ext_w-1:0]  w_sum;

  logic [1:0]          r_sync;
  logic                r_key_db;
  logic [c_db_w-1:0]   r_db_cnt;
  logic                r_key_evt;
  logic [1:0]          r_speed;
  logic                w_key_diff;
  logic                w_db_done;

  assign w_tick     = bus.enable && (r_pre == c_pre_last);
  assign w_boundary = w_tick && (r_us == c_us_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre          <= '0;
      r_us           <= '0;
      r_period_start <= 1'b0;
    end else if (!bus.enable) begin
      r_pre          <= '0;
      r_us           <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_pre <= '0;
        r_us  <= (r_us == c_us_last) ? '0 : r_us + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  // Extra headroom bit keeps the saturation compares free of wrap-around.
  assign w_step = c_ext_w'(1) << r_speed;
  assign w_sum  = {1'b0, r_duty} + w_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_duty  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
      w_duty_nxt  = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_UP;
        S_UP: if (w_boundary) begin
          if (w_sum >= c_level_ext) begin
            w_duty_nxt  = c_level_max;
            w_hold_nxt  = '0;
            w_state_nxt = (HOLD_PERIODS == 0) ? S_DOWN : S_HOLD_HI;
          end else begin
            w_duty_nxt = w_sum[DUTY_W-1:0];
          end
        end
        S_HOLD_HI, S_HOLD_LO: if (w_boundary) begin
          if (r_hold == c_hold_last) begin
            w_hold_nxt  = '0;
            w_state_nxt = (r_state == S_HOLD_HI) ? S_DOWN : S_UP;
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
        S_DOWN: if (w_boundary) begin
          if ({1'b0, r_duty} <= w_step) begin
            w_duty_nxt  = '0;
            w_hold_nxt  = '0;
            w_state_nxt = (HOLD_PERIODS == 0) ? S_UP : S_HOLD_LO;
          end else begin
            w_duty_nxt = r_duty - w_step[DUTY_W-1:0];
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Counter measures how long the synchronized key has disagreed with the debounced level.
  assign w_key_diff = (r_sync[1] != r_key_db);
  assign w_db_done  = w_key_diff && (r_db_cnt == c_db_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_key_db  <= 1'b1;
      r_db_cnt  <= '0;
      r_key_evt <= 1'b0;
      r_speed   <= 2'd0;
    end else begin
      r_sync    <= {r_sync[0], bus.key_n};
      r_key_evt <= w_db_done && !r_sync[1];
      if (!w_key_diff) begin
        r_db_cnt <= '0;
      end else if (w_db_done) begin
        r_db_cnt <= '0;
        r_key_db <= r_sync[1];
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (w_db_done && !r_sync[1]) begin
        r_speed <= r_speed + 2'd1;
      end
    end
  end

  assign bus.duty         = r_duty;
  assign bus.period_start = r_period_start;
  assign bus.state        = r_state;
  assign bus.speed        = r_speed;
  assign bus.key_evt      = r_key_evt;

endmodule
`default_nettype wire

// File: tb/tb_breath_envelope.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_breath_envelope : directed self-checking bench               |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_breath_envelope;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  breath_envelope_if #(.DUTY_W(4)) bif ();

  breath_envelope #(
    .CLK_PER_US  (2),
    .PERIOD_US   (8),
    .DUTY_W      (4),
    .HOLD_PERIODS(2),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(output int n);
    bit found;
    found = 0;
    n = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (bif.period_start) begin
        n = i;
        found = 1;
      end
    end
    if (!found) begin
      check("ps_timeout", 0, 1);
      n = -1;
    end
  endtask

  // exp_n <= 0 skips the interval comparison.
  task automatic ps_check(input string tag, input int exp_duty, input int exp_state,
                          input int exp_n);
    int n;
    wait_ps(n);
    check({tag, "_duty"}, int'(bif.duty), exp_duty);
    check({tag, "_state"}, int'(bif.state), exp_state);
    if (exp_n > 0) check({tag, "_interval"}, n, exp_n);
  endtask

  task automatic run_count(input int n, output int evts, output int first, output int pss);
    evts = 0;
    first = 0;
    pss = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bif.key_evt) begin
        evts++;
        if (first == 0) first = i;
      end
      if (bif.period_start) pss++;
    end
  endtask

  task automatic press(output int evts);
    int e1, e2, f, p;
    bif.key_n = 1'b0;
    run_count(8, e1, f, p);
    bif.key_n = 1'b1;
    run_count(8, e2, f, p);
    evts = e1 + e2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"}, int'(bif.duty), 0);
    check({tag, "_ps"}, int'(bif.period_start), 0);
    check({tag, "_state"}, int'(bif.state), 0);
    check({tag, "_speed"}, int'(bif.speed), 0);
    check({tag, "_keyevt"}, int'(bif.key_evt), 0);
  endtask

  int t1_duty [19] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1};
  int t1_state[19] = '{1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 3, 4, 4, 1, 1};
  int t2_duty [12] = '{3, 5, 7, 7, 7, 5, 3, 1, 0, 0, 0, 2};
  int t2_state[12] = '{1, 1, 2, 2, 3, 3, 3, 3, 4, 4, 1, 1};
  int t4_duty [11] = '{2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4};
  int t4_state[11] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3};

  initial begin
    int evts, first, pss;
    bif.enable = 1'b0;
    bif.key_n  = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full envelope at speed 0.
    bif.enable = 1'b1;
    @(negedge clk);
    check("idle_to_up_state", int'(bif.state), 1);
    check("idle_to_up_duty", int'(bif.duty), 0);
    ps_check("t1_p0", t1_duty[0], t1_state[0], 15);
    for (int i = 1; i < 19; i++) ps_check($sformatf("t1_p%0d", i), t1_duty[i], t1_state[i], 16);

    // Press during UP at duty 1.
    bif.key_n = 1'b0;
    run_count(10, evts, first, pss);
    bif.key_n = 1'b1;
    check("t2_evt_count", evts, 1);
    check("t2_evt_latency", first, 6);
    check("t2_speed", int'(bif.speed), 1);
    for (int i = 0; i < 12; i++) ps_check($sformatf("t2_p%0d", i), t2_duty[i], t2_state[i], 0);

    // Async reset mid-UP.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    ps_check("t6_restart", 1, 1, 16);

    // Drop enable during DOWN at duty 4.
    for (int i = 0; i < 11; i++) ps_check($sformatf("t4_p%0d", i), t4_duty[i], t4_state[i], 16);
    bif.enable = 1'b0;
    @(negedge clk);
    check("t4_dis_state", int'(bif.state), 0);
    check("t4_dis_duty", int'(bif.duty), 0);
    run_count(40, evts, first, pss);
    check("t4_dis_no_ps", pss, 0);
    bif.enable = 1'b1;
    ps_check("t4_reen", 1, 1, 16);

    // Glitches shorter than the debounce window.
    for (int g = 0; g < 3; g++) begin
      int e;
      bif.key_n = 1'b0;
      run_count(3, e, first, pss);
      evts = (g == 0) ? e : evts + e;
      bif.key_n = 1'b1;
      run_count(2, e, first, pss);
      evts += e;
    end
    begin
      int e;
      run_count(10, e, first, pss);
      evts += e;
    end
    check("t3_glitch_evts", evts, 0);
    check("t3_glitch_speed", int'(bif.speed), 0);

    // Clean presses cycle the speed; speed 3 saturates in one step.
    press(evts);
    check("t5_p1_evts", evts, 1);
    check("t5_p1_speed", int'(bif.speed), 1);
    press(evts);
    check("t5_p2_evts", evts, 1);
    check("t5_p2_speed", int'(bif.speed), 2);
    press(evts);
    check("t5_p3_evts", evts, 1);
    check("t5_p3_speed", int'(bif.speed), 3);
    bif.enable = 1'b0;
    @(negedge clk);
    check("t5_dis_duty", int'(bif.duty), 0);
    bif.enable = 1'b1;
    ps_check("t5_sat", 7, 2, 16);
    check("t5_speed_kept", int'(bif.speed), 3);
    press(evts);
    check("t5_p4_evts", evts, 1);
    check("t5_p4_speed", int'(bif.speed), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
